// File: rtl/hp_pkg.sv
// Shared types for the multi-bar health display: trail FSM states, pixel
// classification codes and the bar placement helper.
package hp_pkg;

  typedef enum logic [1:0] {
    TR_IDLE  = 2'd0,
    TR_HOLD  = 2'd1,
    TR_DRAIN = 2'd2
  } trail_state_t;

  typedef enum logic [1:0] {
    PIX_BG    = 2'd0,
    PIX_FILL  = 2'd1,
    PIX_TRAIL = 2'd2
  } pix_code_t;

  localparam int DRAW_W = 10;

  // Left edge of bar idx in screen coordinates, wrapped to the draw width.
  function automatic logic [DRAW_W-1:0] bar_left(input int x0, input int pitch, input int idx);
    return DRAW_W'(x0 + idx * pitch);
  endfunction

endpackage

// File: rtl/hp_trail.sv
// One bar's per-frame HP latch and damage-trail FSM (idle / hold / drain).
// All state advances only on i_tick so a frame is rendered from frozen values.
module hp_trail
  import hp_pkg::*;
#(
  parameter int HP_W        = 10,
  parameter int HOLD_FRAMES = 30,
  parameter int TRAIL_STEP  = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_tick,
  input  logic [HP_W-1:0] i_hp,
  output logic [HP_W-1:0] o_hp_lat,
  output logic [HP_W-1:0] o_trail,
  output logic            o_zero,
  output trail_state_t    o_state
);

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [HP_W-1:0]   STEP      = HP_W'(TRAIL_STEP);

  trail_state_t      r_state, w_state;
  logic [HP_W-1:0]   r_hp_lat;
  logic [HP_W-1:0]   r_trail, w_trail;
  logic [HOLD_W-1:0] r_hold, w_hold;
  logic              r_zero;
  logic [HP_W-1:0]   w_diff;

  // Heal beats damage beats the hold/drain progression; drain never undershoots.
  always_comb begin
    w_state = r_state;
    w_trail = r_trail;
    w_hold  = r_hold;
    w_diff  = r_trail - i_hp;
    if (i_hp >= r_trail) begin
      w_trail = i_hp;
      w_state = TR_IDLE;
      w_hold  = '0;
    end else if (i_hp < r_hp_lat) begin
      w_state = TR_HOLD;
      w_hold  = HOLD_INIT;
    end else begin
      case (r_state)
        TR_HOLD: begin
          if (r_hold == '0) w_state = TR_DRAIN;
          else              w_hold  = r_hold - HOLD_W'(1);
        end
        TR_DRAIN: begin
          if (w_diff <= STEP) begin
            w_trail = i_hp;
            w_state = TR_IDLE;
          end else begin
            w_trail = r_trail - STEP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= TR_IDLE;
      r_hp_lat <= '0;
      r_trail  <= '0;
      r_hold   <= '0;
      r_zero   <= 1'b0;
    end else if (i_tick) begin
      r_state  <= w_state;
      r_hp_lat <= i_hp;
      r_trail  <= w_trail;
      r_hold   <= w_hold;
      r_zero   <= (i_hp == '0);
    end
  end

  assign o_hp_lat = r_hp_lat;
  assign o_trail  = r_trail;
  assign o_zero   = r_zero;
  assign o_state  = r_state;

endmodule

// File: rtl/hp_bar_multi.sv
// Registered N-bar health overlay: per-bar trail FSMs, global blink phase and
// a one-cycle pixel classifier where the lowest-index bar wins overlaps.
module hp_bar_multi
  import hp_pkg::*;
#(
  parameter int N_BARS       = 2,
  parameter int HP_W         = 10,
  parameter int BAR_X0       = 100,
  parameter int BAR_PITCH    = 320,
  parameter int BAR_Y        = 460,
  parameter int BAR_H        = 10,
  parameter int LOW_THRESH   = 50,
  parameter int BLINK_FRAMES = 16,
  parameter int HOLD_FRAMES  = 30,
  parameter int TRAIL_STEP   = 2,
  localparam int BW          = (N_BARS > 1) ? $clog2(N_BARS) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_tick,
  input  logic [DRAW_W-1:0]        DrawX,
  input  logic [DRAW_W-1:0]        DrawY,
  input  logic [N_BARS*HP_W-1:0]   hp_in,
  output logic [1:0]               pix_code,
  output logic [BW-1:0]            pix_bar,
  output logic [N_BARS-1:0]        hp_zero
);

  localparam int CW      = (HP_W > DRAW_W) ? HP_W : DRAW_W;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [HP_W-1:0]    LOW_T      = HP_W'(LOW_THRESH);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_ph;

  logic [HP_W-1:0]   w_hp_lat [N_BARS];
  logic [HP_W-1:0]   w_trail  [N_BARS];
  trail_state_t      w_state  [N_BARS];
  logic [DRAW_W-1:0] w_dx     [N_BARS];
  logic [N_BARS-1:0] w_fill;
  logic [N_BARS-1:0] w_trl;
  logic [N_BARS-1:0] w_blank;
  logic [DRAW_W-1:0] w_dy;
  logic              w_rows;
  pix_code_t         w_code;
  logic [BW-1:0]     w_bar;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (frame_tick) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Above the bar wraps to a large dy and so falls outside the row window.
  assign w_dy   = DrawY - DRAW_W'(BAR_Y);
  assign w_rows = (w_dy < DRAW_W'(BAR_H));

  for (genvar i = 0; i < N_BARS; i++) begin : g_bar
    hp_trail #(
      .HP_W        (HP_W),
      .HOLD_FRAMES (HOLD_FRAMES),
      .TRAIL_STEP  (TRAIL_STEP)
    ) u_trail (
      .i_clk    (Clk),
      .i_rst_n  (Reset_n),
      .i_tick   (frame_tick),
      .i_hp     (hp_in[i*HP_W +: HP_W]),
      .o_hp_lat (w_hp_lat[i]),
      .o_trail  (w_trail[i]),
      .o_zero   (hp_zero[i]),
      .o_state  (w_state[i])
    );

    assign w_dx[i]    = DrawX - bar_left(BAR_X0, BAR_PITCH, i);
    assign w_blank[i] = r_blink_ph && (w_hp_lat[i] != '0) && (w_hp_lat[i] <= LOW_T);
    assign w_fill[i]  = w_rows && !w_blank[i] && (CW'(w_dx[i]) < CW'(w_hp_lat[i]));
    // An idle bar always has trail equal to hp, so its trail span is empty.
    assign w_trl[i]   = w_rows && (w_state[i] != TR_IDLE) &&
                        (CW'(w_dx[i]) >= CW'(w_hp_lat[i])) &&
                        (CW'(w_dx[i]) <  CW'(w_trail[i]));
  end

  always_comb begin
    w_code = PIX_BG;
    w_bar  = '0;
    for (int i = N_BARS - 1; i >= 0; i--) begin
      if (w_fill[i]) begin
        w_code = PIX_FILL;
        w_bar  = BW'(i);
      end else if (w_trl[i]) begin
        w_code = PIX_TRAIL;
        w_bar  = BW'(i);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_code <= 2'd0;
      pix_bar  <= '0;
    end else begin
      pix_code <= w_code;
      pix_bar  <= w_bar;
    end
  end

endmodule

// File: tb/tb_hp_bar_multi.sv
// Directed bench for hp_bar_multi: latch, trail hold/drain, re-damage, heal,
// blink, zero HP, same-cycle tick sampling and asynchronous reset.
module tb_hp_bar_multi;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [19:0] hp_in = '0;
  logic [1:0]  pix_code;
  logic [0:0]  pix_bar;
  logic [1:0]  hp_zero;

  int n_cmp = 0;
  int n_err = 0;
  int n_ticks = 0;
  logic [2:0] exp_q[$];

  localparam logic [1:0] BG = 2'd0, FL = 2'd1, TR = 2'd2;

  hp_bar_multi dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .hp_in      (hp_in),
    .pix_code   (pix_code),
    .pix_bar    (pix_bar),
    .hp_zero    (hp_zero)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_tick(input int h0, input int h1);
    @(negedge Clk);
    hp_in      = {10'(h1), 10'(h0)};
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    n_ticks++;
  endtask

  task automatic run_ticks(input int n, input int h0, input int h1);
    for (int k = 0; k < n; k++) do_tick(h0, h1);
  endtask

  // Present a pixel, wait one clock, compare code and owning bar.
  task automatic pix(input string tag, input int x, input int y,
                     input logic [1:0] code, input logic bar);
    logic [2:0] e;
    exp_q.push_back({code, bar});
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, ".code"}, 32'(pix_code), 32'(e[2:1]));
    check_eq({tag, ".bar"},  32'(pix_bar),  32'(e[0]));
  endtask

  initial begin
    logic [1:0] exp_fill;
    int tr;

    // Reset state
    #12;
    check_eq("rst.code", 32'(pix_code), 32'd0);
    check_eq("rst.bar",  32'(pix_bar),  32'd0);
    check_eq("rst.zero", 32'(hp_zero),  32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Latch 200 / 150
    do_tick(200, 150);
    pix("init_b0_last", 299, 460, FL, 1'b0);
    pix("init_b0_past", 300, 460, BG, 1'b0);
    pix("init_b1_last", 569, 469, FL, 1'b1);
    pix("init_b1_below", 420, 470, BG, 1'b0);
    pix("init_above", 150, 459, BG, 1'b0);
    check_eq("init.zero", 32'(hp_zero), 32'd0);

    // Damage 200 -> 120: trail holds at 200 for the damage tick plus 30 ticks
    do_tick(120, 150);
    pix("dmg_trail", 250, 465, TR, 1'b0);
    pix("dmg_fill", 219, 465, FL, 1'b0);
    for (int k = 0; k < 30; k++) begin
      do_tick(120, 150);
      pix("hold_trail", 299, 460, TR, 1'b0);
    end
    for (int k = 1; k <= 40; k++) begin
      do_tick(120, 150);
      tr = 200 - 2 * k;
      pix("drain_edge_in", 100 + tr - 1, 460, (tr > 120) ? TR : FL, 1'b0);
      pix("drain_edge_out", 100 + tr, 460, BG, 1'b0);
    end

    // Back up to 200, damage to 120, drain to 160, then re-damage to 80
    do_tick(200, 150);
    pix("heal200", 299, 460, FL, 1'b0);
    do_tick(120, 150);
    run_ticks(30, 120, 150);
    run_ticks(20, 120, 150);
    pix("drain160_in", 259, 460, TR, 1'b0);
    pix("drain160_out", 260, 460, BG, 1'b0);
    do_tick(80, 150);
    pix("redmg_trail_top", 259, 460, TR, 1'b0);
    pix("redmg_trail_bot", 180, 460, TR, 1'b0);
    pix("redmg_fill", 179, 460, FL, 1'b0);
    pix("redmg_out", 260, 460, BG, 1'b0);
    run_ticks(30, 80, 150);
    pix("rehold_still160", 259, 460, TR, 1'b0);
    do_tick(80, 150);
    pix("rehold_drain", 258, 460, BG, 1'b0);
    pix("rehold_drain_in", 257, 460, TR, 1'b0);

    // Damage to 78 (hold), then heal to 180 inside the hold
    do_tick(78, 150);
    do_tick(180, 150);
    pix("heal_fill", 279, 460, FL, 1'b0);
    pix("heal_no_trail", 280, 460, BG, 1'b0);

    // Low HP blink: fill follows the global phase, trail stays drawn
    for (int k = 0; k < 32; k++) begin
      do_tick(40, 150);
      exp_fill = (((n_ticks / 16) % 2) == 1) ? BG : FL;
      pix("blink_fill", 110, 462, exp_fill, 1'b0);
      pix("blink_trail", 200, 462, TR, 1'b0);
    end

    // Zero HP: no fill, trail at dx 0, flag set only for bar 0
    do_tick(0, 150);
    pix("zero_dx0", 100, 460, TR, 1'b0);
    pix("zero_b1", 420, 460, FL, 1'b1);
    check_eq("zero.flag", 32'(hp_zero), 32'd1);

    // Pixel sampled on the tick cycle sees the old state
    @(negedge Clk);
    hp_in      = {10'd150, 10'd100};
    frame_tick = 1'b1;
    DrawX      = 10'd100;
    DrawY      = 10'd460;
    @(posedge Clk);
    #1;
    check_eq("tickcyc_old", 32'(pix_code), 32'(TR));
    @(negedge Clk);
    frame_tick = 1'b0;
    n_ticks++;
    @(posedge Clk);
    #1;
    check_eq("tickcyc_new", 32'(pix_code), 32'(FL));
    check_eq("tickcyc_zero", 32'(hp_zero), 32'd0);

    // Into the drain, then asynchronous reset mid-cycle
    run_ticks(35, 100, 150);
    pix("pre_rst_trail", 200, 460, TR, 1'b0);
    #3;
    Reset_n = 1'b0;
    #1;
    check_eq("arst.code", 32'(pix_code), 32'd0);
    check_eq("arst.bar",  32'(pix_bar),  32'd0);
    check_eq("arst.zero", 32'(hp_zero),  32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    n_ticks = 0;
    pix("post_rst_empty", 150, 460, BG, 1'b0);
    do_tick(100, 150);
    pix("post_rst_fill0", 100, 460, FL, 1'b0);
    pix("post_rst_fill99", 199, 460, FL, 1'b0);
    pix("post_rst_notrail", 200, 460, BG, 1'b0);
    pix("post_rst_b1", 569, 460, FL, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hp_bar_multi.md
# hp_bar_multi

Parametrised, registered health-bar renderer for N ships. Latches each ship's HP once per frame, maintains a per-bar "damage trail" that holds and then drains toward the current HP, blinks low-HP bars, and classifies every `DrawX`/`DrawY` pixel as fill, trail or background with one cycle of latency. Sits between the game-state logic and the colour mapper, replacing the single-frame combinational HP overlay.

## Interface
- `N_BARS`, 2: number of bars/ships.
- `HP_W`, 10: width of each HP value.
- `BAR_X0`, 100: left edge of bar 0.
- `BAR_PITCH`, 320: X spacing between consecutive bars.
- `BAR_Y`, 460: top row of all bars.
- `BAR_H`, 10: bar height in rows.
- `LOW_THRESH`, 50: HP at or below which a non-zero bar blinks.
- `BLINK_FRAMES`, 16: frames per blink half-period.
- `HOLD_FRAMES`, 30: frames the trail holds after damage before draining.
- `TRAIL_STEP`, 2: trail decrement per frame while draining.

- `Clk` in 1: system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse at frame start (vsync edge, synchronous to `Clk`).
- `DrawX` in 10: current pixel column.
- `DrawY` in 10: current pixel row.
- `hp_in` in N_BARS*HP_W: packed HP values, bar i at `[i*HP_W +: HP_W]`.
- `pix_code` out 2: 0 background, 1 fill, 2 trail, 3 reserved (never driven).
- `pix_bar` out clog2(N_BARS) (min 1): index of the bar that owns the pixel; 0 when `pix_code`=0.
- `hp_zero` out N_BARS: registered flag, bar's latched HP is 0.

## Operation
- Per bar: `hp_lat`, `trail` (HP_W bits), `hold_cnt`, state in {TR_IDLE, TR_HOLD, TR_DRAIN}. All updates only on `frame_tick`; between ticks the latched values are frozen (no mid-frame tearing).
- On `frame_tick`, `hp_lat` <= `hp_in[i]`, then the FSM evaluates the new value `h`:
  - `h` >= `trail` (heal or equal): `trail` <= `h`, state TR_IDLE, `hold_cnt` <= 0.
  - `h` < `hp_lat` (new damage, any state): state TR_HOLD, `hold_cnt` <= HOLD_FRAMES-1; `trail` unchanged.
  - TR_HOLD, no new damage: `hold_cnt` decrements; on tick with `hold_cnt`=0 go TR_DRAIN.
  - TR_DRAIN: if `trail` - `h` <= TRAIL_STEP then `trail` <= `h`, TR_IDLE; else `trail` <= `trail` - TRAIL_STEP. No underflow.
- Blink: global frame counter wraps at BLINK_FRAMES-1 and toggles `blink_ph`. Bar blinks if 0 < `hp_lat` <= LOW_THRESH; fill suppressed (reported as background, trail still drawn) while `blink_ph`=1.
- Pixel classification, bar i: `dx` = `DrawX` - (BAR_X0 + i*BAR_PITCH), `dy` = `DrawY` - BAR_Y, both 10-bit unsigned with wrap (left/above wraps large → outside). Inside rows iff `dy` < BAR_H. Fill iff `dx` < `hp_lat`; trail iff `hp_lat` <= `dx` < `trail`. HP 0 draws no fill pixels (strict compare).
- Overlapping bars: lowest index wins.

## Timing
- Reset: `pix_code`=0, `pix_bar`=0, `hp_zero`=all 0; `hp_lat`, `trail`, counters, `blink_ph` = 0; all bars TR_IDLE. Reset mid-frame or mid-drain returns to this state immediately; next `frame_tick` relatches.
- Pixel latency: exactly 1 `Clk`; `pix_code`/`pix_bar` at cycle t+1 reflect `DrawX`/`DrawY` at t and state registered as of t.
- `hp_zero` and state update in the cycle after `frame_tick`; a pixel sampled in the same cycle as `frame_tick` uses the old state.
- `frame_tick` held high multiple cycles is treated as multiple frames (caller guarantees single-cycle pulse).

## Structure
- Package `hp_pkg`: `trail_state_t` enum (TR_IDLE, TR_HOLD, TR_DRAIN), `pix_code_t` constants (PIX_BG, PIX_FILL, PIX_TRAIL).
- Sub-module `hp_trail`: one bar's latch, FSM, hold counter and trail register; instantiated N_BARS times by generate. Top holds blink counter, pixel comparators, priority select and output registers.

## Test plan
- Reset then tick with `hp_in`={200,150}: pixel (100+199,460) → fill bar 0; (300,460) → background; (420+149,469) → fill bar 1; (420,470) → background.
- Bar 0 200→120 on one tick: (100+150,465) → trail for 30 ticks, then trail shrinks by 2/tick, reaching 120 after 40 more ticks; state TR_IDLE.
- Damage during TR_DRAIN (trail=160, hp 120→80): state TR_HOLD, hold restarts, trail stays 160.
- Heal 80→180 while TR_HOLD: trail=180 immediately, no trail pixels, TR_IDLE.
- hp=40: fill pixels visible 16 frames, hidden 16 frames, trail unaffected; hp=0: no fill, `hp_zero[0]`=1.
- Assert `Reset_n` mid-drain: all outputs 0 asynchronously, next tick with hp=100 shows fill 0..99, no trail.
